// File: rtl/ysyx_22040088_rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package ysyx_22040088_rf_pkg;
  localparam int RF_XLEN = 64;
  localparam int RF_NREG = 32;

  function automatic int rf_aw(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

  typedef logic [$clog2(RF_NREG)-1:0] rf_idx_t;
endpackage

// File: rtl/ysyx_22040088_rf_rdport.sv
// One read port: reg-0 zeroing, same-cycle write forwarding and busy masking.
module ysyx_22040088_rf_rdport #(
  parameter int XLEN   = 64,
  parameter int AW     = 5,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]       raddr,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [XLEN-1:0]     stored,
  input  logic                busy_bit,
  output logic [XLEN-1:0]     rdata,
  output logic                rbusy
);
  logic            hit;
  logic [XLEN-1:0] fwd;

  // Ascending scan so the highest-index matching writer is forwarded.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < NWR; k++) begin
      if (BYPASS != 0 && wen[k] && waddr[k*AW +: AW] == raddr) begin
        hit = 1'b1;
        fwd = wdata[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (raddr != '0) begin
      rdata = hit ? fwd : stored;
      rbusy = busy_bit & ~hit;
    end
  end
endmodule

// File: rtl/ysyx_22040088_regfile_mp.sv
// Multi-port GPR file with write-to-read bypass and a per-register busy scoreboard.
module ysyx_22040088_regfile_mp
  import ysyx_22040088_rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREG   = RF_NREG,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = rf_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Later ports overwrite earlier ones, so the highest index wins a conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wen[k] && waddr[k*AW +: AW] != '0)
          rf[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
      end
    end
  end

  // Alloc is applied after retire clears: a new producer supersedes the retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++) begin
      if (wen[k]) busy_nxt[waddr[k*AW +: AW]] = 1'b0;
    end
    if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    ysyx_22040088_rf_rdport #(
      .XLEN  (XLEN),
      .AW    (AW),
      .NWR   (NWR),
      .BYPASS(BYPASS)
    ) u_rdport (
      .raddr   (ra),
      .wen     (wen),
      .waddr   (waddr),
      .wdata   (wdata),
      .stored  (rf[ra]),
      .busy_bit(busy[ra]),
      .rdata   (rdata[i*XLEN +: XLEN]),
      .rbusy   (rbusy[i])
    );
  end
endmodule

// File: tb/tb_ysyx_22040088_regfile_mp.sv
// Directed bench for the multi-port register file with an array-based reference model.
module tb_ysyx_22040088_regfile_mp;
  import ysyx_22040088_rf_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [1:0]    wen;
  rf_idx_t       wa [2];
  logic [63:0]   wd [2];
  rf_idx_t       ra [2];
  logic          alloc_en;
  rf_idx_t       alloc_addr;
  logic [127:0]  rdata;
  logic [1:0]    rbusy;
  logic [31:0]   busy_vec;

  int tests = 0;
  int fails = 0;

  logic [63:0] m_rf   [32];
  logic        m_busy [32];

  ysyx_22040088_regfile_mp #(
    .XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     ({wa[1], wa[0]}),
    .wdata     ({wd[1], wd[0]}),
    .raddr     ({ra[1], ra[0]}),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated once per clock from the rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_rf[r]   <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (wen[k] && wa[k] != 0) m_rf[wa[k]] <= wd[k];
      for (int r = 1; r < 32; r++) begin
        logic set_r, clr_r;
        set_r = alloc_en && alloc_addr == r;
        clr_r = (wen[0] && wa[0] == r) || (wen[1] && wa[1] == r);
        m_busy[r] <= set_r ? 1'b1 : (clr_r ? 1'b0 : m_busy[r]);
      end
    end
  end

  function automatic logic hit_of(input rf_idx_t a);
    return a != 0 && ((wen[0] && wa[0] == a) || (wen[1] && wa[1] == a));
  endfunction

  function automatic logic [63:0] exp_rd(input rf_idx_t a);
    if (a == 0) return 64'd0;
    if (wen[1] && wa[1] == a) return wd[1];
    if (wen[0] && wa[0] == a) return wd[0];
    return m_rf[a];
  endfunction

  function automatic logic [31:0] exp_bv();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = (r != 0) && m_busy[r];
    return v;
  endfunction

  always @(negedge clk) begin
    chk("rdata0", rdata[63:0], exp_rd(ra[0]));
    chk("rdata1", rdata[127:64], exp_rd(ra[1]));
    chk("rbusy0", {63'd0, rbusy[0]}, {63'd0, m_busy[ra[0]] && ra[0] != 0 && !hit_of(ra[0])});
    chk("rbusy1", {63'd0, rbusy[1]}, {63'd0, m_busy[ra[1]] && ra[1] != 0 && !hit_of(ra[1])});
    chk("busy_vec", {32'd0, busy_vec}, {32'd0, exp_bv()});
  end

  task automatic step(input logic [1:0] we, input rf_idx_t a0, input logic [63:0] d0,
                      input rf_idx_t a1, input logic [63:0] d1,
                      input rf_idx_t r0, input rf_idx_t r1,
                      input logic al, input rf_idx_t aa);
    @(posedge clk);
    #1;
    wen = we; wa[0] = a0; wd[0] = d0; wa[1] = a1; wd[1] = d1;
    ra[0] = r0; ra[1] = r1; alloc_en = al; alloc_addr = aa;
  endtask

  task automatic idle(input rf_idx_t r0, input rf_idx_t r1);
    step(2'b00, 0, 0, 0, 0, r0, r1, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    wen = '0; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    ra[0] = 1; ra[1] = 2; alloc_en = 1'b0; alloc_addr = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_rdata0", rdata[63:0], 64'd0);
    chk("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int r = 1; r < 32; r++) begin
      idle(rf_idx_t'(r), rf_idx_t'(r));
      #2;
      chk("init_rd0", rdata[63:0], 64'd0);
      chk("init_rd1", rdata[127:64], 64'd0);
      chk("init_rbusy", {62'd0, rbusy}, 64'd0);
    end

    step(2'b01, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 5, 0, 1'b0, 0);
    #2 chk("x5_bypass", rdata[63:0], 64'hDEAD_BEEF_0000_0001);
    idle(5, 5);
    #2 chk("x5_stored", rdata[127:64], 64'hDEAD_BEEF_0000_0001);

    step(2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1'b0, 0);
    #2 chk("x0_bypass", rdata[63:0], 64'd0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 0);
    idle(0, 0);
    #2 chk("x0_stored", rdata[63:0], 64'd0);
    chk("x0_alloc", {32'd0, busy_vec}, 64'd0);

    step(2'b00, 0, 0, 0, 0, 7, 7, 1'b1, 7);
    idle(7, 7);
    #2 chk("x7_busy", {62'd0, rbusy}, 64'd3);
    step(2'b01, 7, 64'd42, 0, 0, 7, 7, 1'b0, 0);
    #2 chk("x7_retire_rbusy", {62'd0, rbusy}, 64'd0);
    chk("x7_retire_data", rdata[63:0], 64'd42);
    idle(7, 0);
    #2 chk("x7_cleared", {63'd0, busy_vec[7]}, 64'd0);

    step(2'b01, 7, 64'd99, 0, 0, 7, 0, 1'b1, 7);
    #2 chk("x7_same_rbusy", {63'd0, rbusy[0]}, 64'd0);
    idle(7, 0);
    #2 chk("x7_set_wins", {63'd0, busy_vec[7]}, 64'd1);
    chk("x7_new_data", rdata[63:0], 64'd99);

    step(2'b11, 9, 64'd1, 9, 64'd2, 9, 9, 1'b0, 0);
    #2 chk("x9_bypass_hi", rdata[63:0], 64'd2);
    idle(9, 9);
    #2 chk("x9_stored_hi", rdata[127:64], 64'd2);

    for (int r = 10; r < 20; r++)
      step(2'b11, rf_idx_t'(r), 64'(r * 3), rf_idx_t'(r + 10), 64'(r * 5),
           rf_idx_t'(r - 1), rf_idx_t'(r + 10), 1'b1, rf_idx_t'(r + 1));
    idle(12, 25);
    #2 chk("x12_stored", rdata[63:0], 64'd36);
    chk("x25_stored", rdata[127:64], 64'd75);

    step(2'b01, 3, 64'd7, 0, 0, 3, 4, 1'b1, 4);
    idle(3, 4);
    #1;
    chk("x3_before_rst", rdata[63:0], 64'd7);
    chk("x4_before_rst", {63'd0, busy_vec[4]}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("x3_after_rst", rdata[63:0], 64'd0);
    chk("x4_after_rst", {63'd0, busy_vec[4]}, 64'd0);
    chk("bv_after_rst", {32'd0, busy_vec}, 64'd0);
    rst_n = 1'b1;

    idle(9, 5);
    #2 chk("x9_after_rst", rdata[63:0], 64'd0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
